// File: rtl/isa_types.sv
// Shared ISA widths, opcode encodings, sequencer state type and opcode helpers.
package isa_types;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPC_W = 7;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OPC_LOAD   = 7'h03;
    localparam opcode_t OPC_OP_IMM = 7'h13;
    localparam opcode_t OPC_AUIPC  = 7'h17;
    localparam opcode_t OPC_STORE  = 7'h23;
    localparam opcode_t OPC_OP     = 7'h33;
    localparam opcode_t OPC_LUI    = 7'h37;
    localparam opcode_t OPC_BRANCH = 7'h63;
    localparam opcode_t OPC_JALR   = 7'h67;
    localparam opcode_t OPC_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } seq_state_t;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_legal_opcode(input opcode_t op);
        case (op)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input opcode_t op);
        return !(op == OPC_STORE || op == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running event counter with enable and synchronous active-low clear.
module retire_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hart_sequencer.sv
// Multi-cycle hart control: fetch, decode hold, execute, memory, writeback,
// owning PC, IR, memory handshakes, write strobes and the retire count.
module hart_sequencer
    import isa_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instr_bits,
    input  opcode_t         opcode,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            reg_we,
    output logic            pc_we,
    output seq_state_t      state,
    output logic            trap,
    output logic [63:0]     instret
);

    seq_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] ir_q, ir_d;
    logic            imem_req_q, imem_req_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic            reg_we_q, reg_we_d;
    logic            pc_we_q, pc_we_d;
    logic            trap_q, trap_d;
    logic            retire_c;

    // Next state plus request/strobe outputs registered one step ahead.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        reg_we_d = 1'b0;
        pc_we_d  = 1'b0;
        retire_c = 1'b0;

        case (state_q)
            FETCH: begin
                if (imem_req_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (ir_q[1:0] != 2'b11 || !is_legal_opcode(opcode)) begin
                    state_d = TRAP;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_d = MEMORY;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                if (dmem_ready) begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                if (next_pc[1:0] != 2'b00) begin
                    state_d = TRAP;
                end else begin
                    pc_d     = next_pc;
                    pc_we_d  = 1'b1;
                    reg_we_d = writes_rd(opcode);
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase

        imem_req_d = (state_d == FETCH);
        dmem_req_d = (state_d == MEMORY);
        dmem_we_d  = (state_d == MEMORY) && (opcode == OPC_STORE);
        trap_d     = (state_d == TRAP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            pc_we_q    <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
            pc_we_q    <= pc_we_d;
            trap_q     <= trap_d;
        end
    end

    retire_counter #(.W(64)) u_retire_counter (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (retire_c),
        .count (instret)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instr_bits = ir_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign reg_we     = reg_we_q;
    assign pc_we      = pc_we_q;
    assign state      = state_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_hart_sequencer.sv
// Scoreboard bench for hart_sequencer: a reactive driver predicts each instruction's
// outcome into a queue, and a negedge monitor pops and compares DUT events.
module tb_hart_sequencer;
    import isa_types::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, instr_bits, next_pc = '0, pc;
    opcode_t     opcode;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic        reg_we, pc_we, trap;
    seq_state_t  state;
    logic [63:0] instret;

    always #5 clk = ~clk;

    // Stand-in for the combinational decoder.
    assign opcode = instr_bits[6:0];

    hart_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_bits(instr_bits), .opcode(opcode),
        .next_pc(next_pc), .pc(pc), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .reg_we(reg_we), .pc_we(pc_we),
        .state(state), .trap(trap), .instret(instret)
    );

    typedef struct {
        logic [31:0] fetch_pc;
        logic [31:0] word;
        bit          trap;
        int          lat;
        logic [31:0] pc;
        logic [63:0] instret;
        bit          reg_we;
        bit          store;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_pc = RESET_PC_DEFAULT;
    logic [63:0] model_instret = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endfunction

    // Instruction table: word plus its architectural class.
    function automatic void describe(input int idx, output logic [31:0] word, output bit legal,
                                     output bit mem, output bit store, output bit wr, output bit jump);
        legal = 1; mem = 0; store = 0; wr = 1; jump = 0;
        case (idx)
            0:  word = 32'h00500093;                        // addi x1,x0,5
            1:  word = 32'h002081B3;                        // add x3,x1,x2
            2:  word = 32'h123450B7;                        // lui
            3:  word = 32'h00001117;                        // auipc
            4:  begin word = 32'h008000EF; jump = 1; end    // jal
            5:  begin word = 32'h000080E7; jump = 1; end    // jalr
            6:  begin word = 32'h00208463; jump = 1; wr = 0; end  // beq
            7:  begin word = 32'h0000A103; mem = 1; end     // lw
            8:  begin word = 32'h0020A023; mem = 1; store = 1; wr = 0; end  // sw
            9:  begin word = 32'hFFFFFFFF; legal = 0; end
            10: begin word = 32'h00000001; legal = 0; end
            default: begin word = 32'h0000000B; legal = 0; end
        endcase
    endfunction

    // Monitor: decoupled from stimulus, pops an expectation per retire/trap event.
    int          cyc = 0;
    int          start_cyc = 0;
    bit          in_flight = 0;
    bit          trap_prev = 0;
    bit          rst_seen = 0;
    logic [31:0] frz_pc = '0;
    logic [63:0] frz_ir = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            rst_seen  = 1;
            in_flight = 0;
            trap_prev = 0;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                chk("rst_state", 64'(state), 64'(FETCH));
                chk("rst_pc", 64'(pc), 64'(RESET_PC_DEFAULT));
                chk("rst_instret", instret, 64'd0);
                chk("rst_ir", 64'(instr_bits), 64'd0);
                chk("rst_outs", 64'({trap, imem_req, dmem_req, dmem_we, reg_we, pc_we}), 64'd0);
            end
            if (pc_we || reg_we || (trap && !trap_prev)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("event_in_flight", 64'(in_flight), 64'(1));
                    chk("event_is_trap", 64'(trap), 64'(e.trap));
                    chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
                    chk("pc", 64'(pc), 64'(e.pc));
                    chk("instret", instret, e.instret);
                    chk("reg_we", 64'(reg_we), 64'(e.reg_we));
                    chk("pc_we", 64'(pc_we), 64'(!e.trap));
                    chk("ir_held", 64'(instr_bits), 64'(e.word));
                    if (e.trap) begin
                        frz_pc = e.pc;
                        frz_ir = e.instret;
                    end
                end
                in_flight = 0;
            end else if (trap) begin
                chk("trap_quiet", 64'({imem_req, dmem_req, reg_we, pc_we}), 64'd0);
                chk("trap_pc_frozen", 64'(pc), 64'(frz_pc));
                chk("trap_instret_frozen", instret, frz_ir);
                chk("trap_state", 64'(state), 64'(TRAP));
            end
            trap_prev = trap;
            if (imem_req) begin
                if (!in_flight) begin
                    start_cyc = cyc;
                    in_flight = 1;
                end
                if (exp_q.size() != 0) chk("imem_addr", 64'(imem_addr), 64'(exp_q[0].fetch_pc));
            end
            if (dmem_req && exp_q.size() != 0) begin
                chk("dmem_we", 64'(dmem_we), 64'(exp_q[0].store));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ready = 0;
        dmem_ready = 0;
        reset_n    = 0;
        tick();
        reset_n = 1;
        exp_q.delete();
        model_pc      = RESET_PC_DEFAULT;
        model_instret = '0;
    endtask

    // Drive one instruction through the DUT and push its predicted outcome.
    task automatic run_instr(input int idx, input int w, input int d, input bit misalign,
                             input bit use_tgt, input logic [31:0] tgt, input bit rst_mid);
        logic [31:0] word, np;
        bit legal, mem, store, wr, jump, trap_exp;
        exp_t e;
        int n = 0;
        while (!imem_req && n < 40) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!imem_req) begin
            chk("fetch_timeout", 64'(0), 64'(1));
            do_reset();
            return;
        end
        dmem_ready = 0;
        describe(idx, word, legal, mem, store, wr, jump);
        if (use_tgt)   np = tgt;
        else if (jump) np = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        else           np = model_pc + 32'd4;
        if (misalign)  np[1:0] = 2'($urandom_range(1, 3));
        trap_exp   = !legal || (np[1:0] != 2'b00);
        e.fetch_pc = model_pc;
        e.word     = word;
        e.trap     = trap_exp;
        e.lat      = !legal ? 2 + w : 4 + w + (mem ? 1 + d : 0);
        if (!trap_exp) begin
            model_pc      = np;
            model_instret = model_instret + 64'd1;
        end
        e.pc      = model_pc;
        e.instret = model_instret;
        e.reg_we  = !trap_exp && wr;
        e.store   = store;
        exp_q.push_back(e);

        next_pc    = np;
        imem_rdata = word;
        for (int k = 0; k <= w; k++) begin
            imem_ready = (k == w);
            tick();
        end
        imem_ready = 0;
        imem_rdata = $urandom;

        if (legal && mem) begin
            n = 0;
            while (!dmem_req && n < 10) begin
                dmem_ready = 1'($urandom_range(0, 1));
                imem_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            imem_ready = 0;
            if (!dmem_req) begin
                chk("dmem_timeout", 64'(0), 64'(1));
                do_reset();
                return;
            end
            for (int k = 0; k <= d; k++) begin
                if (rst_mid && k == 1) begin
                    do_reset();
                    return;
                end
                dmem_ready = (k == d);
                tick();
            end
            dmem_ready = 0;
        end

        if (trap_exp) begin
            n = 0;
            while (!trap && n < 20) begin
                tick();
                n++;
            end
            if (!trap) chk("trap_timeout", 64'(0), 64'(1));
            repeat (20) begin
                imem_ready = 1'($urandom_range(0, 1));
                dmem_ready = 1'($urandom_range(0, 1));
                next_pc    = $urandom;
                tick();
            end
            do_reset();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, w, d;
        bit mis, rmid;
        tick();
        do_reset();
        run_instr(0, 0, 0, 0, 0, 32'h0, 0);                // addi, zero wait
        run_instr(8, 0, 3, 0, 0, 32'h0, 0);                // sw, 3 data waits
        run_instr(9, 0, 0, 0, 0, 32'h0, 0);                // illegal word
        run_instr(0, 0, 0, 0, 0, 32'h0, 0);
        run_instr(4, 0, 0, 0, 1, 32'h0000_0102, 0);        // jal to misaligned target
        run_instr(7, 0, 3, 0, 0, 32'h0, 1);                // reset during memory wait
        for (int i = 0; i < 10; i++) run_instr(1, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 150; i++) begin
            idx  = int'($urandom_range(0, 11));
            w    = int'($urandom_range(0, 2));
            d    = int'($urandom_range(0, 2));
            mis  = ($urandom_range(0, 7) == 0);
            rmid = (idx == 7 || idx == 8) && d >= 1 && ($urandom_range(0, 15) == 0);
            run_instr(idx, w, d, mis, 0, 32'h0, rmid);
        end
        repeat (8) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
